// File: rtl/rob_multi_pkg.sv
// Shared reorder-buffer definitions: default depth, tag-width helper,
// branch-direction constants and the retire-decision encoding.
package rob_multi_pkg;

  localparam int ROB_DEPTH = 16;

  // Branch direction values shared by the predicted and resolved flags.
  localparam logic NOT_JUMP = 1'b0;
  localparam logic JUMP     = 1'b1;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    RET_NONE,
    RET_COMMIT,
    RET_STORE,
    RET_FLUSH
  } retire_e;

endpackage

// File: rtl/rob_multi_if.sv
// Pipeline-facing bundle of the reorder buffer: allocation, writeback,
// operand lookup, commit, store handshake and flush/redirect.
interface rob_multi_if
  import rob_multi_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    localparam int TAG_W = tag_w(DEPTH);

    logic             alloc_valid, alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [REG_W-1:0] alloc_rd;
    logic [XLEN-1:0]  alloc_pc;
    logic             alloc_is_store, alloc_is_br, alloc_pred;

    logic             ex_valid, ex_taken;
    logic [TAG_W-1:0] ex_tag;
    logic [XLEN-1:0]  ex_data, ex_npc;

    logic             slb_valid;
    logic [TAG_W-1:0] slb_tag;
    logic [XLEN-1:0]  slb_data;

    logic [TAG_W-1:0] q0_tag, q1_tag;
    logic             q0_rdy, q1_rdy;
    logic [XLEN-1:0]  q0_data, q1_data;

    logic             cm_valid;
    logic [REG_W-1:0] cm_rd;
    logic [XLEN-1:0]  cm_data;
    logic [TAG_W-1:0] cm_tag;

    logic             st_valid, st_ready;
    logic [TAG_W-1:0] st_tag;

    logic             flush_o;
    logic [XLEN-1:0]  redirect_pc;
    logic [TAG_W:0]   count;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_pc, alloc_is_store, alloc_is_br, alloc_pred,
        input  ex_valid, ex_tag, ex_data, ex_taken, ex_npc,
        input  slb_valid, slb_tag, slb_data,
        input  q0_tag, q1_tag, st_ready,
        output alloc_ready, alloc_tag, q0_rdy, q0_data, q1_rdy, q1_data,
        output cm_valid, cm_rd, cm_data, cm_tag, st_valid, st_tag,
        output flush_o, redirect_pc, count
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_pc, alloc_is_store, alloc_is_br, alloc_pred,
        output ex_valid, ex_tag, ex_data, ex_taken, ex_npc,
        output slb_valid, slb_tag, slb_data,
        output q0_tag, q1_tag, st_ready,
        input  alloc_ready, alloc_tag, q0_rdy, q0_data, q1_rdy, q1_data,
        input  cm_valid, cm_rd, cm_data, cm_tag, st_valid, st_tag,
        input  flush_o, redirect_pc, count
    );

endinterface

// File: rtl/rob_multi_fwd_read.sv
// One operand-lookup port: entry-file read with same-cycle forwarding from
// the EX and SLB writeback ports (EX has priority).
module rob_fwd_read #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic [DEPTH-1:0]           i_busy,
    input  logic [DEPTH-1:0]           i_done,
    input  logic [DEPTH-1:0][XLEN-1:0] i_data,
    input  logic [TAG_W-1:0]           i_q_tag,
    input  logic                       i_ex_valid,
    input  logic [TAG_W-1:0]           i_ex_tag,
    input  logic [XLEN-1:0]            i_ex_data,
    input  logic                       i_slb_valid,
    input  logic [TAG_W-1:0]           i_slb_tag,
    input  logic [XLEN-1:0]            i_slb_data,
    output logic                       o_rdy,
    output logic [XLEN-1:0]            o_data
);

    always_comb begin
        // NOTE: every output gets a default before the ifs, so no latch is inferred.
        o_rdy  = i_busy[i_q_tag] && i_done[i_q_tag];
        o_data = i_data[i_q_tag];
        if (i_ex_valid && (i_ex_tag == i_q_tag)) begin
            o_rdy  = 1'b1;
            o_data = i_ex_data;
        end else if (i_slb_valid && (i_slb_tag == i_q_tag)) begin
            o_rdy  = 1'b1;
            o_data = i_slb_data;
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Parametrised reorder buffer: in-order retire of one entry per cycle, store
// handshake with the SLB, and single-cycle flush on a mispredicted branch.
module rob_multi
  import rob_multi_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    rob_multi_if.slave   bus
);

    localparam int             TAG_W = tag_w(DEPTH);
    localparam logic [TAG_W:0] FULL  = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]            r_busy, r_done, r_is_store, r_is_br, r_pred, r_taken;
    logic [DEPTH-1:0][REG_W-1:0] r_rd;
    logic [DEPTH-1:0][XLEN-1:0]  r_data, r_npc;
    logic [TAG_W-1:0]            r_head, r_tail;
    logic [TAG_W:0]              r_count;
    logic                        r_flush;
    logic [XLEN-1:0]             r_redirect;

    retire_e w_ret;
    logic    w_alloc, w_retire;

    // Head decision; the instruction pc is carried on the bus but retire never needs it.
    always_comb begin
        w_ret = RET_NONE;
        if (rdy && (r_count != '0) && r_busy[r_head] && r_done[r_head]) begin
            if (r_is_store[r_head])
                w_ret = RET_STORE;
            else if (r_is_br[r_head] && (r_taken[r_head] != r_pred[r_head]))
                w_ret = RET_FLUSH;
            else
                w_ret = RET_COMMIT;
        end
    end

    assign bus.alloc_ready = rdy && (r_count < FULL) && !r_flush;
    assign bus.alloc_tag   = r_tail;
    assign bus.cm_valid    = (w_ret == RET_COMMIT) || (w_ret == RET_FLUSH);
    assign bus.cm_rd       = r_rd[r_head];
    assign bus.cm_data     = r_data[r_head];
    assign bus.cm_tag      = r_head;
    assign bus.st_valid    = (w_ret == RET_STORE);
    assign bus.st_tag      = r_head;
    assign bus.flush_o     = r_flush;
    assign bus.redirect_pc = r_redirect;
    assign bus.count       = r_count;

    assign w_alloc  = bus.alloc_valid && bus.alloc_ready;
    assign w_retire = (w_ret == RET_COMMIT) || (w_ret == RET_STORE && bus.st_ready);

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
        if (rst) begin
            // NOTE: only busy/pointers are reset; payload fields are qualified by busy and stay unreset.
            r_busy     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_flush    <= 1'b0;
            r_redirect <= '0;
        end else if (rdy) begin
            r_flush <= 1'b0;
            if (w_ret == RET_FLUSH) begin
                r_busy     <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_flush    <= 1'b1;
                r_redirect <= r_npc[r_head];
            end else begin
                if (w_alloc) begin
                    r_busy[r_tail]     <= 1'b1;
                    r_done[r_tail]     <= bus.alloc_is_store;
                    r_is_store[r_tail] <= bus.alloc_is_store;
                    r_is_br[r_tail]    <= bus.alloc_is_br;
                    r_pred[r_tail]     <= bus.alloc_pred;
                    r_taken[r_tail]    <= NOT_JUMP;
                    r_rd[r_tail]       <= bus.alloc_rd;
                    r_tail             <= r_tail + 1'b1;
                end
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_alloc && !w_retire)
                    r_count <= r_count + 1'b1;
                else if (!w_alloc && w_retire)
                    r_count <= r_count - 1'b1;

                // SLB first so a same-tag EX writeback overrides it.
                if (!r_flush && bus.slb_valid && r_busy[bus.slb_tag]) begin
                    r_done[bus.slb_tag] <= 1'b1;
                    r_data[bus.slb_tag] <= bus.slb_data;
                end
                if (!r_flush && bus.ex_valid && r_busy[bus.ex_tag]) begin
                    r_done[bus.ex_tag]  <= 1'b1;
                    r_data[bus.ex_tag]  <= bus.ex_data;
                    r_taken[bus.ex_tag] <= bus.ex_taken;
                    r_npc[bus.ex_tag]   <= bus.ex_npc;
                end
            end
        end
    end

    rob_fwd_read #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_fwd_q0 (
        .i_busy(r_busy), .i_done(r_done), .i_data(r_data), .i_q_tag(bus.q0_tag),
        .i_ex_valid(bus.ex_valid), .i_ex_tag(bus.ex_tag), .i_ex_data(bus.ex_data),
        .i_slb_valid(bus.slb_valid), .i_slb_tag(bus.slb_tag), .i_slb_data(bus.slb_data),
        .o_rdy(bus.q0_rdy), .o_data(bus.q0_data)
    );

    rob_fwd_read #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_fwd_q1 (
        .i_busy(r_busy), .i_done(r_done), .i_data(r_data), .i_q_tag(bus.q1_tag),
        .i_ex_valid(bus.ex_valid), .i_ex_tag(bus.ex_tag), .i_ex_data(bus.ex_data),
        .i_slb_valid(bus.slb_valid), .i_slb_tag(bus.slb_tag), .i_slb_data(bus.slb_data),
        .o_rdy(bus.q1_rdy), .o_data(bus.q1_data)
    );

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill/full, out-of-order writeback, store
// handshake, mispredict flush, forwarding lookups, wrap-around and reset.
module tb_rob_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    rob_multi_if bus ();

    rob_multi dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        bus.alloc_valid = 0; bus.alloc_rd = '0; bus.alloc_pc = '0;
        bus.alloc_is_store = 0; bus.alloc_is_br = 0; bus.alloc_pred = 0;
        bus.ex_valid = 0; bus.ex_tag = '0; bus.ex_data = '0; bus.ex_taken = 0; bus.ex_npc = '0;
        bus.slb_valid = 0; bus.slb_tag = '0; bus.slb_data = '0;
        bus.q0_tag = '0; bus.q1_tag = '0; bus.st_ready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rdy = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic st, input logic br, input logic pred);
        bus.alloc_valid = 1; bus.alloc_rd = rd; bus.alloc_pc = 32'h1000;
        bus.alloc_is_store = st; bus.alloc_is_br = br; bus.alloc_pred = pred;
        tick();
        bus.alloc_valid = 0; bus.alloc_is_store = 0; bus.alloc_is_br = 0; bus.alloc_pred = 0;
    endtask

    task automatic ex_wb(input logic [3:0] tag, input logic [31:0] data,
                         input logic taken, input logic [31:0] npc);
        bus.ex_valid = 1; bus.ex_tag = tag; bus.ex_data = data;
        bus.ex_taken = taken; bus.ex_npc = npc;
    endtask

    logic [31:0] ooo_exp [4];

    initial begin
        // Reset state
        do_reset();
        settle();
        check("rst_cm_valid", bus.cm_valid, 0);
        check("rst_st_valid", bus.st_valid, 0);
        check("rst_flush", bus.flush_o, 0);
        check("rst_redirect", bus.redirect_pc, 0);
        check("rst_alloc_ready", bus.alloc_ready, 1);
        check("rst_alloc_tag", bus.alloc_tag, 0);
        check("rst_count", bus.count, 0);

        // Fill all 16 entries, then full behaviour and alloc+retire together
        for (int i = 0; i < 16; i++) begin
            settle();
            check("fill_tag", bus.alloc_tag, 64'(i));
            alloc(5'(i + 1), 0, 0, 0);
        end
        settle();
        check("full_count", bus.count, 16);
        check("full_alloc_ready", bus.alloc_ready, 0);
        check("full_no_commit", bus.cm_valid, 0);
        ex_wb(4'd0, 32'hA0, 0, 0);
        tick();
        ex_wb(4'd1, 32'hA1, 0, 0);
        settle();
        check("wb0_cm_valid", bus.cm_valid, 1);
        check("wb0_cm_rd", bus.cm_rd, 1);
        check("wb0_cm_data", bus.cm_data, 32'hA0);
        check("wb0_cm_tag", bus.cm_tag, 0);
        check("wb0_still_full", bus.alloc_ready, 0);
        tick();
        bus.ex_valid = 0;
        bus.alloc_valid = 1; bus.alloc_rd = 5'd17;
        settle();
        check("ar_count_before", bus.count, 15);
        check("ar_alloc_ready", bus.alloc_ready, 1);
        check("ar_alloc_tag_wrap", bus.alloc_tag, 0);
        check("ar_cm_tag", bus.cm_tag, 1);
        check("ar_cm_valid", bus.cm_valid, 1);
        tick();
        bus.alloc_valid = 0;
        settle();
        check("ar_count_held", bus.count, 15);
        check("ar_alloc_tag_next", bus.alloc_tag, 1);
        check("ar_no_commit", bus.cm_valid, 0);

        // Out-of-order writeback, in-order commit; EX beats SLB on same tag
        do_reset();
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 0, 0, 0);
        ooo_exp = '{32'h44, 32'h11, 32'h22, 32'h33};
        ex_wb(4'd3, 32'h33, 0, 0);
        tick();
        bus.ex_valid = 0;
        bus.slb_valid = 1; bus.slb_tag = 4'd1; bus.slb_data = 32'h11;
        settle();
        check("ooo_wait3", bus.cm_valid, 0);
        tick();
        ex_wb(4'd2, 32'h22, 0, 0);
        bus.slb_tag = 4'd2; bus.slb_data = 32'hBAD;
        settle();
        check("ooo_wait1", bus.cm_valid, 0);
        tick();
        bus.slb_valid = 0;
        ex_wb(4'd0, 32'h44, 0, 0);
        settle();
        check("ooo_wait2", bus.cm_valid, 0);
        tick();
        bus.ex_valid = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("ooo_cm_valid", bus.cm_valid, 1);
            check("ooo_cm_tag", bus.cm_tag, 64'(k));
            check("ooo_cm_rd", bus.cm_rd, 64'(k + 1));
            check("ooo_cm_data", bus.cm_data, ooo_exp[k]);
            tick();
        end
        settle();
        check("ooo_empty_cm", bus.cm_valid, 0);
        check("ooo_empty_count", bus.count, 0);

        // Store at head held by st_ready low, plus a rdy=0 freeze
        do_reset();
        alloc(5'd0, 1, 0, 0);
        alloc(5'd7, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("st_hold_valid", bus.st_valid, 1);
            check("st_hold_tag", bus.st_tag, 0);
            check("st_hold_no_cm", bus.cm_valid, 0);
            tick();
        end
        rdy = 0;
        settle();
        check("rdy0_st_valid", bus.st_valid, 0);
        check("rdy0_alloc_ready", bus.alloc_ready, 0);
        tick();
        rdy = 1;
        settle();
        check("st_after_rdy", bus.st_valid, 1);
        check("st_count", bus.count, 2);
        bus.st_ready = 1;
        ex_wb(4'd1, 32'h77, 0, 0);
        tick();
        bus.st_ready = 0; bus.ex_valid = 0;
        settle();
        check("st_retired", bus.st_valid, 0);
        check("st_next_cm", bus.cm_valid, 1);
        check("st_next_tag", bus.cm_tag, 1);
        check("st_next_count", bus.count, 1);

        // Mispredicted branch at tag 2
        do_reset();
        alloc(5'd3, 0, 0, 0);
        alloc(5'd4, 0, 0, 0);
        alloc(5'd1, 0, 1, 0);
        alloc(5'd5, 0, 0, 0);
        ex_wb(4'd0, 32'h100, 0, 0);
        bus.slb_valid = 1; bus.slb_tag = 4'd1; bus.slb_data = 32'h200;
        tick();
        bus.slb_valid = 0;
        ex_wb(4'd2, 32'h1004, 1, 32'h1040);
        settle();
        check("br_cm0", bus.cm_tag, 0);
        tick();
        bus.ex_valid = 0;
        settle();
        check("br_cm1_data", bus.cm_data, 32'h200);
        tick();
        settle();
        check("br_cm_valid", bus.cm_valid, 1);
        check("br_cm_tag", bus.cm_tag, 2);
        check("br_cm_rd", bus.cm_rd, 1);
        check("br_cm_data", bus.cm_data, 32'h1004);
        check("br_no_flush_yet", bus.flush_o, 0);
        tick();
        bus.alloc_valid = 1;
        ex_wb(4'd3, 32'h55, 0, 0);
        settle();
        check("fl_flush", bus.flush_o, 1);
        check("fl_redirect", bus.redirect_pc, 32'h1040);
        check("fl_count", bus.count, 0);
        check("fl_alloc_ready", bus.alloc_ready, 0);
        check("fl_no_cm", bus.cm_valid, 0);
        tick();
        bus.alloc_valid = 0; bus.ex_valid = 0;
        settle();
        check("post_fl_flush", bus.flush_o, 0);
        check("post_fl_alloc_tag", bus.alloc_tag, 0);
        check("post_fl_count", bus.count, 0);
        check("post_fl_ready", bus.alloc_ready, 1);

        // Operand lookup with same-cycle forwarding
        do_reset();
        for (int i = 0; i < 6; i++) alloc(5'(i), 0, 0, 0);
        bus.q0_tag = 4'd5;
        ex_wb(4'd5, 32'hDEAD, 0, 0);
        bus.q1_tag = 4'd4;
        bus.slb_valid = 1; bus.slb_tag = 4'd4; bus.slb_data = 32'hBEEF;
        settle();
        check("q0_fwd_rdy", bus.q0_rdy, 1);
        check("q0_fwd_data", bus.q0_data, 32'hDEAD);
        check("q1_slb_rdy", bus.q1_rdy, 1);
        check("q1_slb_data", bus.q1_data, 32'hBEEF);
        tick();
        bus.ex_valid = 0; bus.slb_valid = 0;
        bus.q1_tag = 4'd3;
        settle();
        check("q0_stored_rdy", bus.q0_rdy, 1);
        check("q0_stored_data", bus.q0_data, 32'hDEAD);
        check("q1_not_done", bus.q1_rdy, 0);
        bus.q0_tag = 4'd9;
        settle();
        check("q0_not_busy", bus.q0_rdy, 0);

        // Wrap-around: 40 alloc/retire pairs
        do_reset();
        for (int i = 0; i < 40; i++) begin
            settle();
            check("wrap_alloc_tag", bus.alloc_tag, 64'(i % 16));
            alloc(5'(i % 32), 0, 0, 0);
            ex_wb(4'(i % 16), 32'(i), 0, 0);
            tick();
            bus.ex_valid = 0;
            settle();
            check("wrap_cm_tag", bus.cm_tag, 64'(i % 16));
            check("wrap_cm_data", bus.cm_data, 64'(i));
            tick();
        end
        settle();
        check("wrap_count", bus.count, 0);

        // Reset in the flush cycle
        alloc(5'd2, 0, 1, 1);
        ex_wb(4'd8, 32'h84, 0, 32'h2000);
        tick();
        bus.ex_valid = 0;
        settle();
        check("mf_cm_tag", bus.cm_tag, 8);
        tick();
        settle();
        check("mf_flush", bus.flush_o, 1);
        check("mf_redirect", bus.redirect_pc, 32'h2000);
        rst = 1;
        tick();
        rst = 0;
        settle();
        check("mf_rst_flush", bus.flush_o, 0);
        check("mf_rst_redirect", bus.redirect_pc, 0);
        check("mf_rst_alloc_tag", bus.alloc_tag, 0);

        // Reset with a commit pending
        alloc(5'd6, 0, 0, 0);
        alloc(5'd7, 0, 0, 0);
        ex_wb(4'd0, 32'h66, 0, 0);
        tick();
        bus.ex_valid = 0;
        settle();
        check("ms_cm_pending", bus.cm_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        settle();
        check("ms_cm_valid", bus.cm_valid, 0);
        check("ms_st_valid", bus.st_valid, 0);
        check("ms_count", bus.count, 0);
        check("ms_alloc_tag", bus.alloc_tag, 0);
        check("ms_alloc_ready", bus.alloc_ready, 1);
        check("ms_flush", bus.flush_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
